// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: state, opcode and datapath-select encodings shared by the control FSM, ALU decoder and datapath
package rv_ctrl_pkg;
  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADR = 4'd2, S_MEM_READ = 4'd3,
                         S_MEM_WB = 4'd4, S_MEM_WRITE = 4'd5, S_EXEC_R = 4'd6, S_EXEC_I = 4'd7,
                         S_ALU_WB = 4'd8, S_BRANCH = 4'd9, S_JAL = 4'd10, S_FAULT = 4'd11;
  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111;
  localparam logic [1:0] ALU_ADD = 2'b00, ALU_BR = 2'b01, ALU_FUNCT = 2'b10;
  localparam logic [1:0] SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RS1 = 2'b10;
  localparam logic [1:0] SRCB_RS2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALU = 2'b10;
  localparam logic [1:0] CAUSE_NONE = 2'b00, CAUSE_ILLEGAL = 2'b01, CAUSE_TIMEOUT = 2'b10;
  function automatic logic is_wait(input logic [3:0] s);
    return s == S_FETCH || s == S_MEM_READ || s == S_MEM_WRITE;
  endfunction
endpackage

// File: rtl/mc_control_fsm_if.sv
// mc_control_fsm_if: control bundle between the sequencer (master) and the datapath (slave)
interface mc_control_fsm_if;
  logic [6:0] opcode;
  logic cond_true, mem_ready;
  logic mem_read, mem_write, adr_src, ir_write, pc_update, branch, reg_write, instr_done, fault;
  logic [1:0] alu_src_a, alu_src_b, alu_sel, result_src, fault_cause;
  logic [3:0] state_o;
  modport master (input opcode, cond_true, mem_ready,
                  output mem_read, mem_write, adr_src, ir_write, pc_update, branch, reg_write,
                         instr_done, fault, alu_src_a, alu_src_b, alu_sel, result_src, fault_cause, state_o);
  modport slave (output opcode, cond_true, mem_ready,
                 input mem_read, mem_write, adr_src, ir_write, pc_update, branch, reg_write,
                       instr_done, fault, alu_src_a, alu_src_b, alu_sel, result_src, fault_cause, state_o);
endinterface

// File: rtl/mc_control_fsm_wd.sv
// mem_wait_watchdog: counts consecutive stalled memory cycles and flags the one that would hit the limit
module mem_wait_watchdog #(
  parameter int WAIT_LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic waiting,
  output logic timeout
);
  localparam int W = WAIT_LIMIT > 0 ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [W-1:0] LIM = W'(WAIT_LIMIT);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= !waiting ? '0 : (cnt == LIM ? cnt : cnt + 1'b1);
  // fires on the stalled cycle that completes the limit, so a ready in that cycle still wins
  assign timeout = WAIT_LIMIT != 0 && waiting && cnt >= LIM - 1'b1;
endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle RV32I main control sequencer with memory watchdog and sticky fault
module mc_control_fsm
  import rv_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 255
) (
  input logic clk,
  input logic rst_n,
  mc_control_fsm_if.master bus
);
  logic [3:0] state, next;
  logic [1:0] cause, next_cause;
  logic rdy, timeout;
  // ready is masked in reset so the FETCH decode cannot raise write enables
  assign rdy = bus.mem_ready & rst_n;
  mem_wait_watchdog #(.WAIT_LIMIT(WAIT_LIMIT)) u_wd (
    .clk(clk), .rst_n(rst_n), .waiting(is_wait(state) && !rdy), .timeout(timeout)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_FETCH;
      cause <= CAUSE_NONE;
    end else begin
      state <= next;
      cause <= next_cause;
    end
  always_comb begin
    next = S_FAULT;
    next_cause = cause;
    case (state)
      S_FETCH:     next = rdy ? S_DECODE : S_FETCH;
      S_DECODE:
        case (bus.opcode)
          OP_LOAD, OP_STORE: next = S_MEM_ADR;
          OP_R:              next = S_EXEC_R;
          OP_I:              next = S_EXEC_I;
          OP_BRANCH:         next = S_BRANCH;
          OP_JAL:            next = S_JAL;
          default:           next_cause = CAUSE_ILLEGAL;
        endcase
      S_MEM_ADR:   next = bus.opcode == OP_LOAD ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  next = rdy ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: next = rdy ? S_FETCH : S_MEM_WRITE;
      S_EXEC_R, S_EXEC_I, S_JAL: next = S_ALU_WB;
      S_MEM_WB, S_ALU_WB, S_BRANCH: next = S_FETCH;
      default:     next = S_FAULT;
    endcase
    if (timeout) begin
      next = S_FAULT;
      next_cause = CAUSE_TIMEOUT;
    end
  end
  always_comb begin
    bus.mem_read    = state == S_FETCH || state == S_MEM_READ;
    bus.mem_write   = state == S_MEM_WRITE;
    bus.adr_src     = state == S_MEM_READ || state == S_MEM_WRITE;
    bus.ir_write    = state == S_FETCH && rdy;
    bus.pc_update   = (state == S_FETCH && rdy) || state == S_JAL || (state == S_BRANCH && bus.cond_true);
    bus.branch      = state == S_BRANCH;
    bus.alu_src_a   = state inside {S_DECODE, S_JAL} ? SRCA_OLDPC :
                      state inside {S_MEM_ADR, S_EXEC_R, S_EXEC_I, S_BRANCH} ? SRCA_RS1 : SRCA_PC;
    bus.alu_src_b   = state inside {S_FETCH, S_JAL} ? SRCB_FOUR :
                      state inside {S_DECODE, S_MEM_ADR, S_EXEC_I} ? SRCB_IMM : SRCB_RS2;
    bus.alu_sel     = state inside {S_EXEC_R, S_EXEC_I} ? ALU_FUNCT : state == S_BRANCH ? ALU_BR : ALU_ADD;
    bus.result_src  = state == S_FETCH ? RES_ALU : state == S_MEM_WB ? RES_DATA : RES_ALUOUT;
    bus.reg_write   = state inside {S_MEM_WB, S_ALU_WB};
    bus.instr_done  = state inside {S_MEM_WB, S_ALU_WB, S_BRANCH} || (state == S_MEM_WRITE && rdy);
    bus.fault       = state == S_FAULT;
    bus.fault_cause = cause;
    bus.state_o     = state;
  end
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: directed and random instruction streams checked against an instruction-level model
module tb_mc_control_fsm;
  import rv_ctrl_pkg::*;
  localparam int LIM = 4;
  typedef struct packed {
    logic mr, mw, adr, irw, pcu, br;
    logic [1:0] a, b, sel, res;
    logic rw, done, flt;
    logic [1:0] cause;
    logic [3:0] st;
  } outs_t;
  logic clk = 0;
  logic rst_n = 1;
  int checks = 0, errors = 0;
  mc_control_fsm_if bus ();
  mc_control_fsm #(.WAIT_LIMIT(LIM)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  logic [3:0] m_step = S_FETCH;
  logic [1:0] m_cause = 2'b00;
  int m_wait = 0;
  logic [3:0] m_route[$];
  outs_t c_got, c_exp;
  function automatic outs_t observed();
    return '{bus.mem_read, bus.mem_write, bus.adr_src, bus.ir_write, bus.pc_update, bus.branch,
             bus.alu_src_a, bus.alu_src_b, bus.alu_sel, bus.result_src,
             bus.reg_write, bus.instr_done, bus.fault, bus.fault_cause, bus.state_o};
  endfunction
  function automatic outs_t expect_of(input logic [3:0] s, input logic rdy, input logic cnd, input logic [1:0] cause);
    outs_t e = '0;
    e.st = s;
    e.cause = cause;
    case (s)
      S_FETCH:     begin e.mr = 1; e.irw = rdy; e.pcu = rdy; e.b = 2'b10; e.res = 2'b10; end
      S_DECODE:    begin e.a = 2'b01; e.b = 2'b01; end
      S_MEM_ADR:   begin e.a = 2'b10; e.b = 2'b01; end
      S_MEM_READ:  begin e.mr = 1; e.adr = 1; end
      S_MEM_WB:    begin e.res = 2'b01; e.rw = 1; e.done = 1; end
      S_MEM_WRITE: begin e.mw = 1; e.adr = 1; e.done = rdy; end
      S_EXEC_R:    begin e.a = 2'b10; e.sel = 2'b10; end
      S_EXEC_I:    begin e.a = 2'b10; e.b = 2'b01; e.sel = 2'b10; end
      S_ALU_WB:    begin e.rw = 1; e.done = 1; end
      S_BRANCH:    begin e.a = 2'b10; e.sel = 2'b01; e.br = 1; e.done = 1; e.pcu = cnd; end
      S_JAL:       begin e.a = 2'b01; e.b = 2'b10; e.pcu = 1; end
      default:     e.flt = 1;
    endcase
    return e;
  endfunction
  // instruction-level model: each opcode expands to its list of steps; memory steps repeat while not ready
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_step = S_FETCH; m_cause = 2'b00; m_wait = 0; m_route.delete();
    end else if (m_step == S_FAULT) begin
      m_wait = 0;
    end else if ((m_step == S_FETCH || m_step == S_MEM_READ || m_step == S_MEM_WRITE) && !bus.mem_ready) begin
      m_wait++;
      if (m_wait >= LIM) begin m_step = S_FAULT; m_cause = 2'b10; end
    end else begin
      m_wait = 0;
      if (m_step == S_FETCH)
        case (bus.opcode)
          7'b0000011: m_route = '{S_DECODE, S_MEM_ADR, S_MEM_READ, S_MEM_WB};
          7'b0100011: m_route = '{S_DECODE, S_MEM_ADR, S_MEM_WRITE};
          7'b0110011: m_route = '{S_DECODE, S_EXEC_R, S_ALU_WB};
          7'b0010011: m_route = '{S_DECODE, S_EXEC_I, S_ALU_WB};
          7'b1100011: m_route = '{S_DECODE, S_BRANCH};
          7'b1101111: m_route = '{S_DECODE, S_JAL, S_ALU_WB};
          default:    m_route = '{S_DECODE, S_FAULT};
        endcase
      if (m_route.size() == 0) m_step = S_FETCH;
      else begin
        m_step = m_route.pop_front();
        if (m_step == S_FAULT) m_cause = 2'b01;
      end
    end
  end
  always @(negedge clk) begin
    #2;
    c_exp = expect_of(m_step, bus.mem_ready & rst_n, bus.cond_true, m_cause);
    c_got = observed();
    checks++;
    if (c_got !== c_exp) begin
      errors++;
      $display("FAIL cycle_outputs t=%0t: got %h expected %h", $time, c_got, c_exp);
    end
  end
  task automatic lit(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask
  task automatic cyc(input logic rdy, input logic cnd, output outs_t o);
    bus.mem_ready = rdy;
    bus.cond_true = cnd;
    #3 o = observed();
    @(negedge clk);
  endtask
  task automatic do_reset();
    outs_t r = '0;
    rst_n = 0;
    bus.mem_ready = 0;
    r.mr = 1; r.b = 2'b10; r.res = 2'b10; r.st = S_FETCH;
    #3 lit("reset_outputs", int'(observed()), int'(r));
    @(negedge clk);
    rst_n = 1;
  endtask
  task automatic run_instr(input logic [6:0] op, input logic cnd, input int nw,
                           output int cycles, output int pcu, output int dones, output int sel3, output int last_res);
    outs_t o;
    logic rdy;
    bus.opcode = op;
    cycles = 0; pcu = 0; dones = 0; sel3 = -1; last_res = -1;
    for (int i = 0; i < 40; i++) begin
      rdy = 1;
      if ((m_step == S_MEM_READ || m_step == S_MEM_WRITE) && nw > 0) begin rdy = 0; nw--; end
      cyc(rdy, cnd, o);
      cycles++;
      pcu += int'(o.pcu);
      dones += int'(o.done);
      if (cycles == 3) sel3 = int'(o.sel);
      last_res = int'(o.res);
      if (m_step == S_FETCH || m_step == S_FAULT) break;
    end
  endtask
  initial begin
    outs_t o, f;
    int cy, pc, dn, s3, lr;
    bus.opcode = 7'b0110011; bus.cond_true = 0; bus.mem_ready = 0;
    #1 rst_n = 0;
    @(negedge clk);
    do_reset();
    run_instr(7'b0110011, 0, 0, cy, pc, dn, s3, lr);
    lit("r_cycles", cy, 4); lit("r_alu_sel_c3", s3, 2); lit("r_done", dn, 1);
    run_instr(7'b0000011, 0, 3, cy, pc, dn, s3, lr);
    lit("lw_wait3_cycles", cy, 8); lit("lw_result_src_wb", lr, 1);
    run_instr(7'b0100011, 0, 1, cy, pc, dn, s3, lr);
    lit("sw_wait1_cycles", cy, 5);
    run_instr(7'b0010011, 0, 0, cy, pc, dn, s3, lr);
    lit("i_cycles", cy, 4);
    run_instr(7'b1100011, 1, 0, cy, pc, dn, s3, lr);
    lit("br_taken_cycles", cy, 3); lit("br_taken_pcu", pc, 2); lit("br_alu_sel", s3, 1);
    run_instr(7'b1100011, 0, 0, cy, pc, dn, s3, lr);
    lit("br_not_taken_cycles", cy, 3); lit("br_not_taken_pcu", pc, 1);
    run_instr(7'b1101111, 0, 0, cy, pc, dn, s3, lr);
    lit("jal_cycles", cy, 4); lit("jal_pcu", pc, 2); lit("jal_done", dn, 1);
    bus.opcode = 7'b1111111;
    for (int i = 0; i < 22; i++) cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), o);
    f = '0; f.flt = 1; f.cause = 2'b01; f.st = S_FAULT;
    lit("illegal_fault", int'(o), int'(f));
    do_reset();
    for (int i = 0; i < 4; i++) cyc(0, 0, o);
    lit("timeout_4th_wait_still_fetch", int'(o.st), int'(S_FETCH));
    cyc(0, 0, o);
    f.cause = 2'b10;
    lit("timeout_fault", int'(o), int'(f));
    do_reset();
    bus.opcode = 7'b0110011;
    for (int i = 0; i < 3; i++) cyc(0, 0, o);
    cyc(1, 0, o);
    cyc(1, 0, o);
    lit("ready_at_limit_decode", int'(o.st), int'(S_DECODE));
    lit("ready_at_limit_no_fault", int'(o.flt), 0);
    for (int n = 0; n < 4000; n++) begin
      if (m_step == S_FETCH)
        bus.opcode = $urandom_range(0, 9) < 9 ?
          (7'b0000011 << 0) ^ 7'($urandom_range(0, 5) == 0 ? 7'b0000000 :
                                $urandom_range(0, 4) == 0 ? 7'b0100000 :
                                $urandom_range(0, 3) == 0 ? 7'b0110000 :
                                $urandom_range(0, 2) == 0 ? 7'b0010000 :
                                $urandom_range(0, 1) == 0 ? 7'b1100000 : 7'b1101100) : 7'($urandom);
      if ((m_step == S_FAULT && $urandom_range(0, 7) == 0) || $urandom_range(0, 299) == 0) do_reset();
      else cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), o);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multi-cycle main control sequencer for the RV32I core. Decodes the IR opcode, steps the shared datapath (single memory port, single ALU, register file) through fetch/decode/execute/writeback, and drives the 2-bit `alu_sel` consumed by the ALU decoder. It also handles the memory ready handshake, a wait-timeout watchdog, and a sticky fault state.

## Interface
- `WAIT_LIMIT`, default 255: consecutive `mem_ready`-low cycles before a timeout fault; 0 disables the watchdog.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 7: IR[6:0].
- `cond_true` in 1: branch condition from the datapath (zero/lt flag, already selected).
- `mem_ready` in 1: memory accepted/completed the current access.
- `mem_read` out 1: read request.
- `mem_write` out 1: write request.
- `adr_src` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `ir_write` out 1: load IR and oldPC.
- `pc_update` out 1: PC write enable.
- `branch` out 1: branch state indicator.
- `alu_src_a` out 2: 00 = PC, 01 = oldPC, 10 = rs1 reg.
- `alu_src_b` out 2: 00 = rs2 reg, 01 = imm, 10 = const 4.
- `alu_sel` out 2: 00 = add, 01 = branch compare, 10 = funct-decoded.
- `result_src` out 2: 00 = ALUOut, 01 = data reg, 10 = ALU result.
- `reg_write` out 1: register file write enable.
- `instr_done` out 1: one-cycle pulse when an instruction retires.
- `fault` out 1: sticky fault flag.
- `fault_cause` out 2: 01 = illegal opcode, 10 = memory timeout.
- `state_o` out 4: current state, for debug.

## Operation
- States: FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, ALU_WB, BRANCH, JAL, FAULT.
- Output defaults: every output is 0 unless the state line below lists it.
- Output style: outputs are Moore (decoded from state). Exceptions are `ir_write`, `pc_update` and `instr_done`, which are qualified by `mem_ready` or `cond_true` as stated.
- FETCH:
  - Drives `mem_read`=1, `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, `alu_sel`=00, `result_src`=10.
  - On `mem_ready`=1: `ir_write`=1 and `pc_update`=1 in the same cycle, then go to DECODE. Otherwise stay.
- DECODE:
  - Drives `alu_src_a`=01, `alu_src_b`=01, `alu_sel`=00 (precomputes the branch/jump target).
  - Next state by opcode: 0000011/0100011 → MEM_ADR; 0110011 → EXEC_R; 0010011 → EXEC_I; 1100011 → BRANCH; 1101111 → JAL; anything else → FAULT with cause 01.
- MEM_ADR: `alu_src_a`=10, `alu_src_b`=01, `alu_sel`=00. Go to MEM_READ if `opcode`=0000011, else MEM_WRITE.
- MEM_READ: `mem_read`=1, `adr_src`=1. On `mem_ready` go to MEM_WB.
- MEM_WB: `result_src`=01, `reg_write`=1, `instr_done`=1. Go to FETCH.
- MEM_WRITE: `mem_write`=1, `adr_src`=1. On `mem_ready`: `instr_done`=1, go to FETCH.
- EXEC_R: `alu_src_a`=10, `alu_src_b`=00, `alu_sel`=10. Go to ALU_WB.
- EXEC_I: `alu_src_a`=10, `alu_src_b`=01, `alu_sel`=10. Go to ALU_WB.
- ALU_WB: `result_src`=00, `reg_write`=1, `instr_done`=1. Go to FETCH.
- BRANCH:
  - Drives `alu_src_a`=10, `alu_src_b`=00, `alu_sel`=01, `result_src`=00, `branch`=1, `instr_done`=1.
  - `pc_update`=`cond_true`. Go to FETCH.
- JAL:
  - Drives `alu_src_a`=01, `alu_src_b`=10, `alu_sel`=00, `result_src`=00, `pc_update`=1 (PC ← target held in ALUOut).
  - Go to ALU_WB (rd ← oldPC+4).
- FAULT: all control outputs 0, `fault`=1. Sticky; only `rst_n` leaves it.
- Watchdog:
  - A wait counter increments each cycle spent in FETCH, MEM_READ or MEM_WRITE with `mem_ready`=0. It clears on any state change or on `mem_ready`=1.
  - When the counter reaches `WAIT_LIMIT` (nonzero), the next state is FAULT with cause 10.
  - Counter width is clog2(`WAIT_LIMIT`+1); it saturates and never wraps.
- `mem_ready` outside FETCH, MEM_READ and MEM_WRITE is ignored.

## Timing
- Reset: `rst_n` low forces state FETCH, clears the counter, and sets `fault`=0 and `fault_cause`=00 immediately (asynchronous).
- Outputs during reset: FETCH decodes, so `mem_read`=1, `alu_src_b`=10 and `result_src`=10; all other outputs are 0.
- First fetch request: issued on the first rising edge after reset release.
- Reset mid-instruction: the instruction is abandoned and no write-enable stays asserted.
- Cycle counts with zero wait: lw 5, sw 4, R 4, I 4, branch 3, jal 4. Each wait cycle adds 1.
- `instr_done`: exactly one pulse per retired instruction, never in FETCH or DECODE.
- Waiting: while waiting, all outputs hold steady; requests stay asserted until the `mem_ready` cycle.
- `mem_ready` at the limit: if `mem_ready`=1 arrives in the same cycle the counter would hit the limit, `mem_ready` wins and there is no fault.

## Structure
- Shared package `rv_ctrl_pkg`: state encoding (4-bit localparams), opcode constants, and the `alu_sel`, `alu_src_a`, `alu_src_b` and `result_src` encodings, so that the ALU decoder and the datapath share them.
- One sub-module, `mem_wait_watchdog`: counter, limit compare, and `timeout` output. Everything else is one state register, a next-state block and an output decode.

## Test plan
- Reset, then `opcode`=0110011 with `mem_ready` always 1 → states FETCH, DECODE, EXEC_R, ALU_WB; `reg_write` and `instr_done` high in cycle 4; `alu_sel`=10 in cycle 3.
- lw with `mem_ready` low for 3 cycles in MEM_READ → 8 cycles total; `mem_read` and `adr_src`=1 held steady; `result_src`=01 during MEM_WB.
- Branch with `cond_true`=1, then again with `cond_true`=0 → `pc_update` 1 then 0 in BRANCH; `alu_sel`=01; 3 cycles each.
- jal → `pc_update` in FETCH and JAL; `reg_write` in ALU_WB; `instr_done` pulses exactly once.
- `opcode`=1111111 → FAULT with `fault_cause`=01, outputs 0 for 20 cycles; `rst_n` pulse returns to FETCH.
- `WAIT_LIMIT`=4, `mem_ready` stuck 0 in FETCH → FAULT with cause 10 after 4 wait cycles. Repeat with `mem_ready`=1 on the 4th cycle → DECODE and no fault.
